// File: rtl/mealy_ctx_arbiter.sv
// Two-requester arbiter time-sharing one Mealy transition/output function over private 2-bit contexts.
// Latency: ready is combinational; the response and context update are registered one cycle after accept.
// Backpressure: none on responses; a requester waits when it loses arbitration or while its context is being cleared.
module mealy_ctx_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req_valid,
    input  logic [1:0] i_req_bit,
    input  logic [1:0] i_ctx_clr,
    output logic [1:0] o_req_ready,
    output logic       o_rsp_valid,
    output logic       o_rsp_id,
    output logic       o_rsp_out,
    output logic [1:0] o_rsp_state,
    output logic [3:0] o_ctx_state
);

    typedef enum logic [1:0] {
        ST_P = 2'b00,
        ST_Q = 2'b01,
        ST_R = 2'b10,
        ST_T = 2'b11
    } ctx_state_t;

    typedef struct packed {
        ctx_state_t nxt;
        logic       out;
    } mealy_t;

    localparam logic [3:0] BURST_CNT = 4'(BURST_LEN);

    function automatic mealy_t mealy_step(input ctx_state_t s, input logic sym);
        mealy_t r;
        r = '{nxt: ST_P, out: 1'b0};
        case (s)
            ST_P:    r = sym ? '{nxt: ST_T, out: 1'b0} : '{nxt: ST_R, out: 1'b1};
            ST_Q:    r = sym ? '{nxt: ST_Q, out: 1'b1} : '{nxt: ST_P, out: 1'b0};
            ST_R:    r = sym ? '{nxt: ST_R, out: 1'b0} : '{nxt: ST_Q, out: 1'b1};
            ST_T:    r = sym ? '{nxt: ST_P, out: 1'b1} : '{nxt: ST_R, out: 1'b0};
            default: r = '{nxt: ST_P, out: 1'b0};
        endcase
        return r;
    endfunction

    ctx_state_t ctx_q [2];
    ctx_state_t ctx_d [2];
    logic       owner_q;
    logic [3:0] cnt_q;

    logic [1:0] eligible;
    logic       other;
    logic       win_vld;
    logic       win_id;
    mealy_t     step_res;

    assign eligible = i_req_valid & ~i_ctx_clr;
    assign other    = ~owner_q;

    // Owner keeps the grant until its burst is used up, but only if the other side is actually waiting.
    always_comb begin
        win_vld = 1'b0;
        win_id  = owner_q;
        if (!rst) begin
            if (eligible[owner_q] && ((cnt_q < BURST_CNT) || !eligible[other])) begin
                win_vld = 1'b1;
                win_id  = owner_q;
            end else if (eligible[other]) begin
                win_vld = 1'b1;
                win_id  = other;
            end
        end
    end

    always_comb begin
        o_req_ready = 2'b00;
        if (win_vld) begin
            o_req_ready[win_id] = 1'b1;
        end
    end

    assign step_res = mealy_step(ctx_q[win_id], i_req_bit[win_id]);

    // A clearing requester is never the winner, so clear and update cannot collide on one context.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            ctx_d[n] = ctx_q[n];
            if (i_ctx_clr[n]) begin
                ctx_d[n] = ST_P;
            end else if (win_vld && (win_id == 1'(n))) begin
                ctx_d[n] = step_res.nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctx_q[0]    <= ST_P;
            ctx_q[1]    <= ST_P;
            owner_q     <= 1'b0;
            cnt_q       <= 4'd0;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= 1'b0;
            o_rsp_out   <= 1'b0;
            o_rsp_state <= 2'b00;
        end else begin
            ctx_q[0] <= ctx_d[0];
            ctx_q[1] <= ctx_d[1];
            if (win_vld) begin
                o_rsp_valid <= 1'b1;
                o_rsp_id    <= win_id;
                o_rsp_out   <= step_res.out;
                o_rsp_state <= step_res.nxt;
                if (win_id == owner_q) begin
                    cnt_q <= (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;
                end else begin
                    owner_q <= win_id;
                    cnt_q   <= 4'd1;
                end
            end else begin
                o_rsp_valid <= 1'b0;
                cnt_q       <= 4'd0;
            end
        end
    end

    assign o_ctx_state = {ctx_q[1], ctx_q[0]};

endmodule

// File: doc/mealy_ctx_arbiter.md
MEALY_CTX_ARBITER -- requirements
Module: mealy_ctx_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, legal 1..15: max consecutive beats one requester gets while the other waits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_req_valid  input  2  per-requester input-bit valid; bit n = requester n.
REQ-005 i_req_bit  input  2  per-requester serial input symbol (0 = a, 1 = b).
REQ-006 i_ctx_clr  input  2  per-requester context clear to state P.
REQ-007 o_req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-008 o_rsp_valid  output  1  registered response valid.
REQ-009 o_rsp_id  output  1  requester index of the response.
REQ-010 o_rsp_out  output  1  Mealy output for the accepted symbol.
REQ-011 o_rsp_state  output  2  requester's new context state after the symbol.
REQ-012 o_ctx_state  output  4  [1:0] = context 0, [3:2] = context 1, registered.

Function
REQ-013 SHALL time-share one Mealy transition/output function between two requesters, holding a private 2-bit context per requester.
REQ-014 State codes: P=00, Q=01, R=10, T=11.
REQ-015 Table (state,sym -> next/out): P,0->R/1; P,1->T/0; Q,0->P/0; Q,1->Q/1; R,0->Q/1; R,1->R/0; T,0->R/0; T,1->P/1.
REQ-016 Beat accepted for n when i_req_valid[n] & o_req_ready[n] in a cycle; eligible[n] = i_req_valid[n] & ~i_ctx_clr[n].
REQ-017 Registered owner pointer g (reset 0) and beat counter cnt (4 bits, reset 0).
REQ-018 Combinational arbitration: owner g wins if eligible[g] and (cnt < BURST_LEN or ~eligible[~g]); else ~g wins if eligible[~g]; else none.
REQ-019 o_req_ready[n] high only for the winner; ready may depend combinationally on i_req_valid and i_ctx_clr.
REQ-020 On accept by owner: cnt <= cnt+1, saturating at 15. On accept by ~g: g <= ~g, cnt <= 1.
REQ-021 Cycle with no accept: g holds, cnt <= 0.
REQ-022 On accept for n: ctx[n] <= next(ctx[n], i_req_bit[n]); other context unchanged.
REQ-023 Response latency 1 cycle: next cycle o_rsp_valid=1, o_rsp_id=n, o_rsp_out/o_rsp_state from the pre-update ctx[n] and accepted symbol.
REQ-024 No accept -> next cycle o_rsp_valid=0; o_rsp_id/out/state hold last values.
REQ-025 No response back-pressure; one beat per cycle sustained throughput.
REQ-026 i_ctx_clr[n]=1: ctx[n] <= P next edge; requester n not granted that cycle (clear beats valid).
REQ-027 Clearing one context never alters the other context, g, or an in-flight response.
REQ-028 Both clears together: both contexts <= P; no accept that cycle.
REQ-029 o_ctx_state reflects registered contexts (updates visible the cycle after accept/clear).

Reset
REQ-030 rst=1 at a rising edge: both contexts <= P, g <= 0, cnt <= 0, o_rsp_valid <= 0, o_rsp_id <= 0, o_rsp_out <= 0, o_rsp_state <= 00.
REQ-031 While rst=1, o_req_ready SHALL be 00; rst overrides accepts and clears in the same cycle.
REQ-032 Reset mid-stream discards any beat presented that cycle; no response for it.

Verification
REQ-033 Req0 only, bits 0,0,0,1 from reset -> responses id0 out 1,1,0,0, state R,Q,P,T; o_ctx_state[1:0]=11.
REQ-034 Both valid continuously, BURST_LEN=4 -> ready pattern 0,0,0,0,1,1,1,1,0... (4-beat alternation); contexts advance independently.
REQ-035 Req1 only valid then req0 valid at cnt=2 -> req1 keeps grant through cnt=4, req0 granted 5th cycle.
REQ-036 Req0 at state T, i_ctx_clr[0]=1 with i_req_valid=11 -> req1 granted that cycle; ctx0=P next cycle; req0 next bit 1 -> out 0, state T.
REQ-037 rst pulsed during alternating traffic -> next cycle o_rsp_valid=0, o_ctx_state=0000, first post-reset grant to req0 when both valid.
REQ-038 Single-cycle valid gaps -> cnt resets to 0, no spurious responses, owner retained.
